// File: rtl/vram_write_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// vram_write_scheduler_pkg
//   Shared definitions for the VideoMemory write scheduler.
//   - VRAM_ADDR_W / PIXEL_W : write-port address ({col,row}) and pixel widths
//   - fill_state_e          : fill FSM state encoding (2-bit)
//   - clamp_extent()        : clips a rectangle extent against the last
//                             writable coordinate, using 9-bit arithmetic
//                             so that origin+size never wraps.
// ---------------------------------------------------------------------------
package vram_write_scheduler_pkg;

    localparam int VRAM_ADDR_W = 16;
    localparam int PIXEL_W     = 3;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_e;

    // Returns 0 when the origin is already past the limit, otherwise the
    // smaller of the requested size and the room left up to the limit.
    function automatic logic [7:0] clamp_extent(
        input logic [7:0] origin,
        input logic [7:0] size,
        input logic [8:0] limit
    );
        logic [8:0] room;
        room = limit - {1'b0, origin} + 9'd1;
        if ({1'b0, origin} > limit) begin
            return 8'd0;
        end else if ({1'b0, size} < room) begin
            return size;
        end else begin
            // room <= size <= 255 here, so it fits in 8 bits
            return room[7:0];
        end
    endfunction

endpackage

// File: rtl/vram_write_scheduler_if.sv
// ---------------------------------------------------------------------------
// vram_write_scheduler_if
//   Bundles the CPU write request, the fill-engine command/status and the
//   VideoMemory write port.
//   master : the requester side (drives CPU/fill requests, sees port+status)
//   slave  : the scheduler (consumes requests, drives port+status)
// ---------------------------------------------------------------------------
interface vram_write_scheduler_if;
    import vram_write_scheduler_pkg::*;

    // CPU VGA-instruction write
    logic                   cpu_we;
    logic [VRAM_ADDR_W-1:0] cpu_addr;
    logic [PIXEL_W-1:0]     cpu_data;

    // Rectangle fill command
    logic                   fill_start;
    logic [7:0]             fill_x;
    logic [7:0]             fill_y;
    logic [7:0]             fill_w;
    logic [7:0]             fill_h;
    logic [PIXEL_W-1:0]     fill_color;

    // Fill status
    logic                   fill_busy;
    logic                   fill_done;

    // VideoMemory write port
    logic                   vram_we;
    logic [VRAM_ADDR_W-1:0] vram_addr;
    logic [PIXEL_W-1:0]     vram_data;

    modport master (
        output cpu_we, cpu_addr, cpu_data,
        output fill_start, fill_x, fill_y, fill_w, fill_h, fill_color,
        input  fill_busy, fill_done,
        input  vram_we, vram_addr, vram_data
    );

    modport slave (
        input  cpu_we, cpu_addr, cpu_data,
        input  fill_start, fill_x, fill_y, fill_w, fill_h, fill_color,
        output fill_busy, fill_done,
        output vram_we, vram_addr, vram_data
    );
endinterface

// File: rtl/vram_write_scheduler_rect_scan_counter.sv
// ---------------------------------------------------------------------------
// rect_scan_counter
//   Nested column/row offset counters for a row-major rectangle scan.
//   Ports:
//     clk_i     : clock
//     rst_i     : synchronous active-high reset (clears offsets)
//     load_i    : restart the scan at offset (0,0)
//     advance_i : step to the next pixel (asserted only when a pixel is
//                 actually written)
//     w_eff_i   : effective width  (non-zero while scanning)
//     h_eff_i   : effective height (non-zero while scanning)
//     col_off_o : current column offset (inner counter)
//     row_off_o : current row offset    (outer counter)
//     last_o    : current pixel is the final one of the rectangle
// ---------------------------------------------------------------------------
module rect_scan_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       advance_i,
    input  logic [7:0] w_eff_i,
    input  logic [7:0] h_eff_i,
    output logic [7:0] col_off_o,
    output logic [7:0] row_off_o,
    output logic       last_o
);
    logic [7:0] col_q, col_d;
    logic [7:0] row_q, row_d;
    logic       col_wrap;

    assign col_wrap = (col_q == w_eff_i - 8'd1);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (load_i) begin
            col_d = 8'd0;
            row_d = 8'd0;
        end else if (advance_i) begin
            if (col_wrap) begin
                col_d = 8'd0;
                row_d = row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= 8'd0;
            row_q <= 8'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_off_o = col_q;
    assign row_off_o = row_q;
    assign last_o    = col_wrap && (row_q == h_eff_i - 8'd1);
endmodule

// File: rtl/vram_write_scheduler.sv
// ---------------------------------------------------------------------------
// vram_write_scheduler
//   Owns the single VideoMemory write port and shares it between CPU
//   VGA-instruction writes (absolute priority, never stalled) and a
//   rectangle-fill engine that yields to the CPU cycle by cycle.
//   Parameters:
//     COL_LIMIT / ROW_LIMIT : last writable column / row; fill pixels beyond
//                             are clipped at start time.
//   Ports:
//     clk_i : clock, all state changes on the rising edge
//     rst_i : synchronous active-high reset
//     bus   : slave side of vram_write_scheduler_if (CPU request, fill
//             command/status, VideoMemory write port)
// ---------------------------------------------------------------------------
module vram_write_scheduler
    import vram_write_scheduler_pkg::*;
#(
    parameter int COL_LIMIT = 255,
    parameter int ROW_LIMIT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    vram_write_scheduler_if.slave bus
);
    fill_state_e        state_q, state_d;
    logic [7:0]         x_q, y_q, w_q, h_q;
    logic [PIXEL_W-1:0] color_q;
    logic               busy_q, done_q;

    logic [7:0]         w_eff, h_eff;
    logic               start_ok;
    logic               fill_we;
    logic [7:0]         col_off, row_off;
    logic               scan_last;

    assign w_eff = clamp_extent(bus.fill_x, bus.fill_w, 9'(COL_LIMIT));
    assign h_eff = clamp_extent(bus.fill_y, bus.fill_h, 9'(ROW_LIMIT));

    assign start_ok = (state_q == FILL_IDLE) && bus.fill_start;

    // The fill writes only when the CPU leaves the port free; reset also
    // masks it so a fill cannot write during the reset cycle itself.
    assign fill_we = (state_q == FILL_RUN) && !bus.cpu_we && !rst_i;

    rect_scan_counter u_scan (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (start_ok),
        .advance_i (fill_we),
        .w_eff_i   (w_q),
        .h_eff_i   (h_q),
        .col_off_o (col_off),
        .row_off_o (row_off),
        .last_o    (scan_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL_IDLE: begin
                if (bus.fill_start) begin
                    state_d = ((w_eff != 8'd0) && (h_eff != 8'd0)) ? FILL_RUN : FILL_DONE;
                end
            end
            FILL_RUN: begin
                if (fill_we && scan_last) begin
                    state_d = FILL_DONE;
                end
            end
            FILL_DONE: state_d = FILL_IDLE;
            default:   state_d = FILL_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with
    // the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL_IDLE;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            w_q     <= 8'd0;
            h_q     <= 8'd0;
            color_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != FILL_IDLE);
            done_q  <= (state_d == FILL_DONE);
            if (start_ok) begin
                x_q     <= bus.fill_x;
                y_q     <= bus.fill_y;
                w_q     <= w_eff;
                h_q     <= h_eff;
                color_q <= bus.fill_color;
            end
        end
    end

    // Write-port mux: CPU first, then fill, else idle zeros.
    always_comb begin
        bus.vram_we   = 1'b0;
        bus.vram_addr = '0;
        bus.vram_data = '0;
        if (bus.cpu_we) begin
            bus.vram_we   = 1'b1;
            bus.vram_addr = bus.cpu_addr;
            bus.vram_data = bus.cpu_data;
        end else if (fill_we) begin
            bus.vram_we   = 1'b1;
            bus.vram_addr = {x_q + col_off, y_q + row_off};
            bus.vram_data = color_q;
        end
    end

    assign bus.fill_busy = busy_q;
    assign bus.fill_done = done_q;
endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed testbench for vram_write_scheduler. Each observation packs
// {we, addr[15:0], data[2:0], busy, done} and is compared to a hand value.
module tb_vram_write_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    vram_write_scheduler_if bus ();

    vram_write_scheduler #(.COL_LIMIT(255), .ROW_LIMIT(255)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic logic [21:0] obs();
        return {bus.vram_we, bus.vram_addr, bus.vram_data, bus.fill_busy, bus.fill_done};
    endfunction

    // Advance one clock; land 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = 16'h0000;
        bus.cpu_data   = 3'd0;
        bus.fill_start = 1'b0;
        bus.fill_x     = 8'd0;
        bus.fill_y     = 8'd0;
        bus.fill_w     = 8'd0;
        bus.fill_h     = 8'd0;
        bus.fill_color = 3'd0;
    endtask

    // Present a start pulse for one edge, then scramble the command inputs.
    task automatic start_fill(input logic [7:0] x, input logic [7:0] y,
                              input logic [7:0] w, input logic [7:0] h,
                              input logic [2:0] c);
        bus.fill_x = x; bus.fill_y = y; bus.fill_w = w; bus.fill_h = h;
        bus.fill_color = c;
        bus.fill_start = 1'b1;
        step();
        bus.fill_start = 1'b0;
        bus.fill_x = 8'hC3; bus.fill_y = 8'h3C; bus.fill_w = 8'h77; bus.fill_h = 8'h11;
        bus.fill_color = 3'd7;
        #1;
    endtask

    task automatic test_reset();
        logic [21:0] e;
        idle_inputs();
        rst = 1'b1;
        step(); step();
        #1;
        e = {1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected %h", obs(), e);
        end
        bus.cpu_we = 1'b1; bus.cpu_addr = 16'h1234; bus.cpu_data = 3'd6;
        #1;
        e = {1'b1, 16'h1234, 3'd6, 1'b0, 1'b0};
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_cpu_passthru: got %h expected %h", obs(), e);
        end
        idle_inputs();
        rst = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_basic_fill();
        logic [15:0] addrs [4];
        logic [21:0] e;
        addrs = '{16'h0A14, 16'h0B14, 16'h0A15, 16'h0B15};
        start_fill(8'd10, 8'd20, 8'd2, 8'd2, 3'd5);
        for (int i = 0; i < 4; i++) begin
            e = {1'b1, addrs[i], 3'd5, 1'b1, 1'b0};
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL basic_pixel%0d: got %h expected %h", i, obs(), e);
            end
            step();
            #1;
        end
        e = {1'b0, 16'h0000, 3'd0, 1'b1, 1'b1};
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL basic_done: got %h expected %h", obs(), e);
        end
        step();
        #1;
        e = {1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL basic_idle_after: got %h expected %h", obs(), e);
        end
        $display("test_basic_fill done");
    endtask

    task automatic test_collision();
        logic [21:0] exp_tab [5];
        exp_tab = '{{1'b1, 16'h0A14, 3'd5, 1'b1, 1'b0},
                    {1'b1, 16'h0102, 3'd3, 1'b1, 1'b0},
                    {1'b1, 16'h0B14, 3'd5, 1'b1, 1'b0},
                    {1'b1, 16'h0A15, 3'd5, 1'b1, 1'b0},
                    {1'b1, 16'h0B15, 3'd5, 1'b1, 1'b0}};
        start_fill(8'd10, 8'd20, 8'd2, 8'd2, 3'd5);
        for (int i = 0; i < 5; i++) begin
            bus.cpu_we   = (i == 1);
            bus.cpu_addr = (i == 1) ? 16'h0102 : 16'h0000;
            bus.cpu_data = (i == 1) ? 3'd3 : 3'd0;
            #1;
            n_checks++;
            if (obs() !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL collision_cycle%0d: got %h expected %h", i, obs(), exp_tab[i]);
            end
            step();
        end
        bus.cpu_we = 1'b0;
        #1;
        n_checks++;
        if (obs() !== {1'b0, 16'h0000, 3'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL collision_done: got %h expected %h", obs(),
                     {1'b0, 16'h0000, 3'd0, 1'b1, 1'b1});
        end
        step();
        $display("test_collision done");
    endtask

    task automatic test_empty();
        logic [7:0] ws [2];
        logic [7:0] hs [2];
        ws = '{8'd0, 8'd3};
        hs = '{8'd3, 8'd0};
        for (int k = 0; k < 2; k++) begin
            start_fill(8'd5, 8'd5, ws[k], hs[k], 3'd1);
            n_checks++;
            if (obs() !== {1'b0, 16'h0000, 3'd0, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL empty%0d_done: got %h expected %h", k, obs(),
                         {1'b0, 16'h0000, 3'd0, 1'b1, 1'b1});
            end
            step();
            #1;
            n_checks++;
            if (obs() !== {1'b0, 16'h0000, 3'd0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL empty%0d_idle: got %h expected %h", k, obs(),
                         {1'b0, 16'h0000, 3'd0, 1'b0, 1'b0});
            end
        end
        $display("test_empty done");
    endtask

    task automatic test_clip();
        logic [21:0] exp_tab [3];
        exp_tab = '{{1'b1, 16'hFE00, 3'd4, 1'b1, 1'b0},
                    {1'b1, 16'hFF00, 3'd4, 1'b1, 1'b0},
                    {1'b0, 16'h0000, 3'd0, 1'b1, 1'b1}};
        start_fill(8'd254, 8'd0, 8'd5, 8'd1, 3'd4);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs() !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL clip_cycle%0d: got %h expected %h", i, obs(), exp_tab[i]);
            end
            step();
            #1;
        end
        $display("test_clip done");
    endtask

    task automatic test_reset_mid_fill();
        start_fill(8'd0, 8'd0, 8'd4, 8'd4, 3'd2);
        step();
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.vram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_we_in_reset: got %b expected 0", bus.vram_we);
        end
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs() !== {1'b0, 16'h0000, 3'd0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL rstmid_after%0d: got %h expected %h", i, obs(),
                         {1'b0, 16'h0000, 3'd0, 1'b0, 1'b0});
            end
            step();
            #1;
        end
        $display("test_reset_mid_fill done");
    endtask

    task automatic test_busy_start();
        logic [21:0] exp_tab [5];
        exp_tab = '{{1'b1, 16'h0101, 3'd2, 1'b1, 1'b0},
                    {1'b1, 16'h0201, 3'd2, 1'b1, 1'b0},
                    {1'b1, 16'h0301, 3'd2, 1'b1, 1'b0},
                    {1'b0, 16'h0000, 3'd0, 1'b1, 1'b1},
                    {1'b0, 16'h0000, 3'd0, 1'b0, 1'b0}};
        start_fill(8'd1, 8'd1, 8'd3, 8'd1, 3'd2);
        for (int i = 0; i < 5; i++) begin
            // Competing start during the fill and during the done cycle.
            bus.fill_start = (i == 0) || (i == 3);
            bus.fill_x = 8'd50; bus.fill_y = 8'd60; bus.fill_w = 8'd2; bus.fill_h = 8'd2;
            bus.fill_color = 3'd6;
            #1;
            n_checks++;
            if (obs() !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL busy_start_cycle%0d: got %h expected %h", i, obs(), exp_tab[i]);
            end
            step();
        end
        bus.fill_start = 1'b0;
        // Idle cycle after done: a fresh start is accepted.
        start_fill(8'd7, 8'd8, 8'd1, 8'd1, 3'd6);
        n_checks++;
        if (obs() !== {1'b1, 16'h0708, 3'd6, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL restart_pixel: got %h expected %h", obs(),
                     {1'b1, 16'h0708, 3'd6, 1'b1, 1'b0});
        end
        step();
        #1;
        n_checks++;
        if (obs() !== {1'b0, 16'h0000, 3'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL restart_done: got %h expected %h", obs(),
                     {1'b0, 16'h0000, 3'd0, 1'b1, 1'b1});
        end
        step();
        $display("test_busy_start done");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_fill();
        test_collision();
        test_empty();
        test_clip();
        test_reset_mid_fill();
        test_busy_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
